// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table, state enum and error codes for the 7-segment capture path
package seg7_pkg;

    // Active-low segment pattern for an all-off digit.
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g, indexed by hex value.
    // This is the same table the hex-to-segment encoder drives.
    localparam logic [6:0] SEG7_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } cap_state_t;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_UNDECODABLE = 2'b01;
    localparam logic [1:0] ERR_MULTI_HOT   = 2'b10;

endpackage

// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - scanned display input and per-digit readback bundle
// master: drives sample_en/seg_in/dig_sel, observes the readback outputs.
// slave : the capture block.
interface seg7_capture_if #(
    parameter int NUM_DIGITS = 6,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);
    logic                    sample_en;
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   valid;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    upd;
    logic                    err;
    logic [1:0]              err_code;
    logic [IDX_W-1:0]        err_digit;

    modport master (
        output sample_en, seg_in, dig_sel,
        input  hex_out, valid, blank, upd, err, err_code, err_digit
    );

    modport slave (
        input  sample_en, seg_in, dig_sel,
        output hex_out, valid, blank, upd, err, err_code, err_digit
    );
endinterface

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational active-low 7-segment pattern to hex nibble decode
// seg    : active-low segment pattern
// hit    : pattern matches one of the 16 hex glyphs
// nibble : decoded value (0 when no hit)
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG7_GLYPH[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - debounced capture of scanned 7-segment traffic into a per-digit hex register file
// clk, rst_n : clock, asynchronous active-low reset
// bus        : seg7_capture_if slave; sample_en/seg_in/dig_sel in,
//              hex_out/valid/blank/upd/err/err_code/err_digit out (all registered)
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seg7_capture_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    // Input stage: plain register, nothing in front of it.
    logic                  smp_en;
    logic [6:0]            smp_seg;
    logic [NUM_DIGITS-1:0] smp_dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_en  <= 1'b0;
            smp_seg <= '0;
            smp_dig <= '0;
        end else begin
            smp_en  <= bus.sample_en;
            smp_seg <= bus.seg_in;
            smp_dig <= bus.dig_sel;
        end
    end

    // Run tracker FSM
    cap_state_t            state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [NUM_DIGITS-1:0] cand_dig, cand_dig_d;
    logic [6:0]            cand_seg, cand_seg_d;
    logic                  commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cand_dig <= '0;
            cand_seg <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cand_dig <= cand_dig_d;
            cand_seg <= cand_seg_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        cand_dig_d = cand_dig;
        cand_seg_d = cand_seg;
        commit     = 1'b0;
        if (smp_en) begin
            if (smp_dig == '0) begin
                // Idle sample: drop the run entirely.
                state_d    = IDLE;
                cnt_d      = '0;
                cand_dig_d = '0;
                cand_seg_d = smp_seg;
            end else if (state != IDLE && smp_dig == cand_dig && smp_seg == cand_seg) begin
                // In TRACK cnt < STABLE_C, so the increment cannot wrap; HELD keeps cnt saturated.
                if (state == TRACK) begin
                    cnt_d = cnt + ONE_C;
                    if (cnt_d == STABLE_C) begin
                        commit  = 1'b1;
                        state_d = HELD;
                    end
                end
            end else begin
                cand_dig_d = smp_dig;
                cand_seg_d = smp_seg;
                cnt_d      = ONE_C;
                if (STABLE_C == ONE_C) begin
                    commit  = 1'b1;
                    state_d = HELD;
                end else begin
                    state_d = TRACK;
                end
            end
        end
    end

    // Decode sits on the candidate register's D side: on any commit it equals the
    // sample being committed, which keeps the single-sample (STABLE_CYCLES = 1) case on time.
    logic       dec_hit;
    logic [3:0] dec_nib;

    seg7_to_hex u_dec (
        .seg    (cand_seg_d),
        .hit    (dec_hit),
        .nibble (dec_nib)
    );

    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d, blank_q, blank_d;
    logic                    upd_q, upd_d, err_q, err_d;
    logic [1:0]              code_q, code_d;
    logic [IW-1:0]           edig_q, edig_d;
    logic                    multi_hot;

    // x & (x-1) is nonzero exactly when more than one bit is set.
    assign multi_hot = |(smp_dig & (smp_dig - NUM_DIGITS'(1)));

    always_comb begin
        hex_d   = hex_q;
        valid_d = valid_q;
        blank_d = blank_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        edig_d  = edig_q;
        if (commit) begin
            upd_d = 1'b1;
            if (multi_hot) begin
                err_d  = 1'b1;
                code_d = ERR_MULTI_HOT;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (smp_dig[i]) begin
                        if (cand_seg_d == SEG7_BLANK) begin
                            valid_d[i] = 1'b0;
                            blank_d[i] = 1'b1;
                        end else if (dec_hit) begin
                            hex_d[4*i +: 4] = dec_nib;
                            valid_d[i]      = 1'b1;
                            blank_d[i]      = 1'b0;
                        end else begin
                            err_d      = 1'b1;
                            code_d     = ERR_UNDECODABLE;
                            edig_d     = IW'(i);
                            valid_d[i] = 1'b0;
                            blank_d[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q   <= '0;
            valid_q <= '0;
            blank_q <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            edig_q  <= '0;
        end else begin
            hex_q   <= hex_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            code_q  <= code_d;
            edig_q  <= edig_d;
        end
    end

    assign bus.hex_out   = hex_q;
    assign bus.valid     = valid_q;
    assign bus.blank     = blank_q;
    assign bus.upd       = upd_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.err_digit = edig_q;

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Capture block for multiplexed 7-segment display traffic, the inverse of the hex-to-segment encoding path. It samples scanned active-low segment lines plus a one-hot digit select, requires each pattern to be held for a configurable number of consecutive samples, and decodes it back to a 4-bit hex value per digit. Its output is a per-digit register file with valid, blank and error reporting. It sits on the debug/loopback side of the display path so the bench and on-chip checkers can read back what the display is actually showing.

## Interface
- NUM_DIGITS, 6: number of scanned digits.
- STABLE_CYCLES, 4: consecutive identical qualified samples required to commit; legal range 1..255.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- sample_en  input  1  qualifies seg_in/dig_sel as a sample this cycle.
- seg_in  input  7  segment lines, active-low, bit 0 = segment a … bit 6 = segment g.
- dig_sel  input  NUM_DIGITS  active-high digit select; must be one-hot or zero.
- hex_out  output  4*NUM_DIGITS  decoded nibble per digit; digit i occupies [4i+3:4i].
- valid  output  NUM_DIGITS  digit i holds a decoded hex value.
- blank  output  NUM_DIGITS  digit i last committed as all-off (7'h7F).
- upd  output  1  one-cycle pulse on every commit, including blank and error commits.
- err  output  1  one-cycle pulse on a rejected commit.
- err_code  output  2  01 = undecodable pattern, 10 = multi-hot dig_sel; held until the next err.
- err_digit  output  $clog2(NUM_DIGITS)  digit index of the last undecodable pattern; held.

## Operation
- Input stage: seg_in, dig_sel and sample_en are registered once, with no other logic ahead of the register.
- Run tracking:
  - Each registered qualified sample is compared to the stored candidate {dig_sel, seg_in}.
  - On a match, the run counter increments, saturating at STABLE_CYCLES.
  - On a mismatch, the candidate is replaced and the counter is set to 1.
  - Unqualified cycles (sample_en=0) neither advance nor break the run.
- Candidates with dig_sel = 0 are idle. They clear the run and never commit.
- States:
  - IDLE: no candidate. A qualified sample with dig_sel ≠ 0 moves to TRACK.
  - TRACK: counting. The counter reaching STABLE_CYCLES triggers a commit and moves to HELD. With STABLE_CYCLES = 1 the commit happens on the first sample.
  - HELD: committed. Further matching samples do nothing. A mismatch reloads the candidate and moves to TRACK. An idle sample moves to IDLE.
- Commit rules:
  - Multi-hot dig_sel: err pulse, err_code=10. No digit state changes.
  - Decodable hex pattern (same glyph set as the encoder, e.g. 7'h40→0, 7'h30→3, 7'h0E→F): hex_out[i] = value, valid[i]=1, blank[i]=0.
  - Blank pattern 7'h7F: valid[i]=0, blank[i]=1. hex_out[i] is unchanged.
  - Any other pattern: err pulse, err_code=01, err_digit=i, valid[i]=0, blank[i]=0. hex_out[i] is unchanged.
- Reset:
  - Reset values: hex_out=0, valid=0, blank=0, upd=0, err=0, err_code=0, err_digit=0, state=IDLE, counter=0.
  - Asserting rst_n mid-run clears everything immediately. No pending commit survives reset.

## Timing
- Latency: if the STABLE_CYCLES-th matching sample is present at the inputs at rising edge E, hex_out/valid/blank/err_code/err_digit change at edge E+1.
  - upd and err are high for exactly the cycle after E+1.
- One commit at most per cycle. Commits to different digits in consecutive cycles are both honoured.
- Outputs are registered, with no combinational input-to-output path.
- Counter width is $clog2(STABLE_CYCLES+1). It never wraps.

## Structure
- Package seg7_pkg holds:
  - SEG7_BLANK (7'h7F).
  - The 16 hex glyph constants, shared with the encoder.
  - The state enum (IDLE, TRACK, HELD).
  - The err_code constants.
- Sub-module seg7_to_hex: combinational 7-bit to {hit, nibble} decode against the package glyph table. Instantiated once, on the candidate register.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs 0 at the next sample point; after release, no upd until a fresh 4-sample run completes.
- Commit: dig_sel=6'b000100, seg_in=7'h30, sample_en=1 for 4 cycles → hex_out[11:8]=3 and valid[2]=1 one cycle after the 4th sample, single upd pulse; 10 more identical samples → no further upd.
- Glitch rejection: 3 samples of 7'h24, 1 sample of 7'h30, 3 samples of 7'h24 on digit 0 → no commit; a 4th consecutive 7'h24 → hex_out[3:0]=2. Gaps with sample_en=0 inside a run do not break it.
- Invalid pattern: digit 1 holds 5, then 4 samples of 7'h2A on digit 1 → err pulse, err_code=01, err_digit=1, valid[1]=0, hex_out[7:4] still 5.
- Blank and multi-hot:
  - 4 samples of 7'h7F on digit 5 → blank[5]=1, valid[5]=0, upd pulse.
  - 4 samples with dig_sel=6'b000011 → err, err_code=10, no digit state change.
- Scan: round-robin digits 0..5 with values 1,2,3,4,5,6, 4 samples each → hex_out=24'h654321, valid=6'h3F, six upd pulses.
